// File: rtl/multi_alarm_pkg.sv
// Shared time-of-day types and the hh:mm:ss increment used by alarm editing.
// The same carry rules serve the time-set logic elsewhere in the clock.
package multi_alarm_pkg;

  localparam int TIME_W  = 18;
  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;
  typedef enum logic [1:0] {FLD_SEC, FLD_MIN, FLD_HOUR} field_e;

  // Increment one field of {hour,min,sec}; sec carries to min, min to hour, hour wraps at 23.
  function automatic logic [TIME_W-1:0] time_inc(input field_e fld, input logic [TIME_W-1:0] t);
    logic [FIELD_W-1:0] h, m, s;
    logic carry_m, carry_h;
    h = t[17:12];
    m = t[11:6];
    s = t[5:0];
    carry_m = 1'b0;
    carry_h = 1'b0;
    if (fld == FLD_SEC) begin
      if (s >= SEC_MAX) begin
        s = '0;
        carry_m = 1'b1;
      end else begin
        s = s + 6'd1;
      end
    end
    if (fld == FLD_MIN || carry_m) begin
      if (m >= MIN_MAX) begin
        m = '0;
        carry_h = 1'b1;
      end else begin
        m = m + 6'd1;
      end
    end
    if (fld == FLD_HOUR || carry_h) begin
      if (h >= HOUR_MAX) h = '0;
      else h = h + 6'd1;
    end
    return {h, m, s};
  endfunction

endpackage

// File: rtl/multi_alarm_channel.sv
// One alarm channel: stored time, match against the running clock, and the
// IDLE/RING/SNOOZE machine with ring timeout and snooze countdown.
module multi_alarm_channel
  import multi_alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_tick,
  input  logic [TIME_W-1:0] cur_clock,
  input  logic              en,
  input  logic              edit,
  input  field_e            field,
  input  logic              guard,
  input  logic              stop,
  input  logic              snooze,
  output state_e            state,
  output state_e            state_nxt,
  output logic [TIME_W-1:0] time_nxt
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int WAIT_W = $clog2(SNOOZE_SECS + 1);
  localparam int SNZ_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SNOOZE_SECS);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [SNZ_W-1:0]  SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  logic [TIME_W-1:0] alm_time_q;
  logic [RING_W-1:0] ring_cnt, ring_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [SNZ_W-1:0]  snz_cnt, snz_cnt_nxt;
  logic              match;

  // A channel being edited is never allowed to fire on its own half-entered time.
  assign match = sec_tick && en && !guard && (cur_clock == alm_time_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_time_q <= '0;
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      wait_cnt   <= '0;
      snz_cnt    <= '0;
    end else begin
      alm_time_q <= time_nxt;
      state      <= state_nxt;
      ring_cnt   <= ring_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      snz_cnt    <= snz_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    wait_cnt_nxt = wait_cnt;
    snz_cnt_nxt  = snz_cnt;
    time_nxt     = edit ? time_inc(field, alm_time_q) : alm_time_q;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else if (edit) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state_nxt    = ST_RING;
            ring_cnt_nxt = '0;
            snz_cnt_nxt  = '0;
          end
        end
        ST_RING: begin
          if (stop) begin
            state_nxt = ST_IDLE;
          end else if (snooze) begin
            if (snz_cnt < SNZ_MAX) begin
              state_nxt    = ST_SNOOZE;
              wait_cnt_nxt = WAIT_LOAD;
              snz_cnt_nxt  = snz_cnt + 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) state_nxt = ST_IDLE;
            else ring_cnt_nxt = ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_nxt = ST_IDLE;
          end else if (match) begin
            state_nxt    = ST_RING;
            ring_cnt_nxt = '0;
          end else if (sec_tick) begin
            if (wait_cnt <= WAIT_ONE) begin
              state_nxt    = ST_RING;
              ring_cnt_nxt = '0;
              wait_cnt_nxt = '0;
            end else begin
              wait_cnt_nxt = wait_cnt - 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_alarm.sv
// N_ALARM independent alarm channels with key editing, a display mux for the
// selected channel, and combined ring indication for the buzzer/LED driver.
module multi_alarm
  import multi_alarm_pkg::*;
#(
  parameter int N_ALARM     = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  localparam int SELW       = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sec_tick,
  input  logic [TIME_W-1:0]  cur_clock,
  input  logic               set_mode,
  input  logic [SELW-1:0]    sel,
  input  logic               hourkey,
  input  logic               minkey,
  input  logic               seckey,
  input  logic [N_ALARM-1:0] en,
  input  logic               stop,
  input  logic               snooze,
  output logic [TIME_W-1:0]  alarm_time,
  output logic [N_ALARM-1:0] ringing,
  output logic               alarming,
  output logic [SELW-1:0]    ring_ch
);

  logic              key_any;
  field_e            field;
  logic [N_ALARM-1:0] guard, edit, ring_nxt;
  state_e            ch_state [N_ALARM];
  state_e            ch_state_nxt [N_ALARM];
  logic [TIME_W-1:0] ch_time_nxt [N_ALARM];
  logic [TIME_W-1:0] alarm_time_nxt;
  logic [SELW-1:0]   ring_ch_nxt;

  // Simultaneous keys collapse to the highest-priority one.
  assign key_any = hourkey | minkey | seckey;
  assign field   = hourkey ? FLD_HOUR : (minkey ? FLD_MIN : FLD_SEC);

  for (genvar c = 0; c < N_ALARM; c++) begin : g_ch
    assign guard[c]   = set_mode && (sel == SELW'(c));
    assign edit[c]    = guard[c] && key_any;
    assign ringing[c] = (ch_state[c] == ST_RING);

    multi_alarm_channel #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sec_tick (sec_tick),
      .cur_clock(cur_clock),
      .en       (en[c]),
      .edit     (edit[c]),
      .field    (field),
      .guard    (guard[c]),
      .stop     (stop),
      .snooze   (snooze),
      .state    (ch_state[c]),
      .state_nxt(ch_state_nxt[c]),
      .time_nxt (ch_time_nxt[c])
    );
  end

  // Registered outputs are built from next-state so they line up with ringing.
  always_comb begin
    ring_nxt       = '0;
    alarm_time_nxt = '0;
    ring_ch_nxt    = '0;
    for (int c = 0; c < N_ALARM; c++) begin
      ring_nxt[c] = (ch_state_nxt[c] == ST_RING);
      if (sel == SELW'(c)) alarm_time_nxt = ch_time_nxt[c];
    end
    for (int c = N_ALARM - 1; c >= 0; c--) begin
      if (ring_nxt[c]) ring_ch_nxt = SELW'(c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_time <= '0;
      alarming   <= 1'b0;
      ring_ch    <= '0;
    end else begin
      alarm_time <= alarm_time_nxt;
      alarming   <= |ring_nxt;
      ring_ch    <= ring_ch_nxt;
    end
  end

endmodule
